// File: rtl/mem_requester.sv
// Single-outstanding command-to-memory requester with a valid/ready
// response, range checking and a saturating error counter.
module mem_requester #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_read_write,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 2);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [23:0] lat_addr;
  logic [15:0] lat_wdata;

  assign cmd_ready = (state == IDLE) && !reset;

  // mem_req is the registered strobe; the bus fields are gated by it
  assign mem_read_write = mem_req & lat_write;
  assign mem_addr  = mem_req ? lat_addr  : 24'h0;
  assign mem_wdata = mem_req ? lat_wdata : 16'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'h0;
      lat_write <= 1'b0;
      lat_addr  <= 24'h0;
      lat_wdata <= 16'h0;
      mem_req   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0;
      rsp_err   <= 1'b0;
      err_count <= 8'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
            rsp_rdata <= 16'h0;
            if (cmd_addr[23:16] == 8'h00) begin
              state   <= ISSUE;
              mem_req <= 1'b1;
              rsp_err <= 1'b0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
          end
        end
        ISSUE: begin
          if (lat_write) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'h0) begin
            state   <= CAPTURE;
            mem_req <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'h1;
          end
        end
        CAPTURE: begin
          state     <= RESP;
          rsp_rdata <= mem_rdata;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a registered-read memory model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_requester;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_read_write;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int rw_viol  = 0;

  logic [15:0] mem [0:255];

  mem_requester #(.READ_LATENCY(2)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req(mem_req),
    .mem_read_write(mem_read_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_req && mem_read_write)
      mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_req && !mem_read_write)
      mem_rdata <= mem[mem_addr[7:0]];
    if (mem_read_write && !mem_req)
      rw_viol <= rw_viol + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic w, input logic [23:0] a,
                      input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 24'h0;
    cmd_wdata = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 0", cmd_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, mem_req, mem_read_write} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b want 0000",
               {rsp_valid, rsp_err, mem_req, mem_read_write});
    end
    n_checks++;
    if ({err_count, rsp_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0",
               {err_count, rsp_rdata, mem_addr, mem_wdata});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rel_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_store();
    send(1'b1, 24'h000010, 16'hBEEF);
    n_checks++;
    if ({mem_req, mem_read_write, mem_addr, mem_wdata, rsp_valid}
        !== {1'b1, 1'b1, 24'h000010, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL st_issue: req=%b rw=%b a=%h d=%h rv=%b want 1 1 000010 beef 0",
               mem_req, mem_read_write, mem_addr, mem_wdata, rsp_valid);
    end
    tick();
    n_checks++;
    if ({mem_req, mem_read_write, mem_addr, mem_wdata} !== 42'h0) begin
      n_fail++;
      $display("FAIL st_memidle: req=%b rw=%b a=%h d=%h want 0",
               mem_req, mem_read_write, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL st_rsp: rv=%b err=%b rd=%h want 1 0 0000",
               rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL st_done: rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_load_hold();
    send(1'b0, 24'h000010, 16'h1234);
    n_checks++;
    if ({mem_req, mem_read_write, mem_addr} !== {2'b10, 24'h000010}) begin
      n_fail++;
      $display("FAIL ld_t1: req=%b rw=%b a=%h want 1 0 000010",
               mem_req, mem_read_write, mem_addr);
    end
    tick();
    n_checks++;
    if ({mem_req, mem_read_write, rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL ld_t2: req=%b rw=%b rv=%b want 1 0 0",
               mem_req, mem_read_write, rsp_valid);
    end
    tick();
    n_checks++;
    if ({mem_req, rsp_valid, mem_addr} !== 26'h0) begin
      n_fail++;
      $display("FAIL ld_t3: req=%b rv=%b a=%h want 0 0 0",
               mem_req, rsp_valid, mem_addr);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL ld_t4: rv=%b err=%b rd=%h want 1 0 beef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    // ignored command activity while the response is pending
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_write = i[0];
      cmd_addr  = 24'h000020 + 24'(i);
      cmd_wdata = 16'(i);
      tick();
      n_checks++;
      if ({rsp_valid, rsp_rdata, cmd_ready, mem_req}
          !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL ld_hold%0d: rv=%b rd=%h rdy=%b req=%b want 1 beef 0 0",
                 i, rsp_valid, rsp_rdata, cmd_ready, mem_req);
      end
    end
    cmd_write = 1'b1;
    cmd_addr  = 24'h000030;
    cmd_wdata = 16'hCAFE;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, mem_req} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_idle: rv=%b rdy=%b req=%b want 0 1 0",
               rsp_valid, cmd_ready, mem_req);
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({cmd_ready, mem_req, mem_read_write, mem_addr, mem_wdata}
        !== {3'b011, 24'h000030, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL b2b_acc: rdy=%b req=%b rw=%b a=%h d=%h want 0 1 1 000030 cafe",
               cmd_ready, mem_req, mem_read_write, mem_addr, mem_wdata);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_error();
    send(1'b0, 24'h010000, 16'h5555);
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_req} !== {2'b11, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_rsp: rv=%b err=%b rd=%h req=%b want 1 1 0000 0",
               rsp_valid, rsp_err, rsp_rdata, mem_req);
    end
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL err_cnt: got %0d want 1", err_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    int bad = 0;
    send(1'b0, 24'h000010, 16'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, rsp_valid, cmd_ready, err_count} !== {3'b001, 8'h0}) begin
      n_fail++;
      $display("FAIL rwait: req=%b rv=%b rdy=%b ec=%0d want 0 0 1 0",
               mem_req, rsp_valid, cmd_ready, err_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || mem_req) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rwait_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_saturate();
    rsp_ready = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      send(1'b1, 24'h800000 | 24'(i), 16'h0);
      tick();
      if (i == 100) begin
        n_checks++;
        if (err_count !== 8'd100) begin
          n_fail++;
          $display("FAIL sat_mid: got %0d want 100", err_count);
        end
      end
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_end: got %0d want 255", err_count);
    end
    n_checks++;
    if (rw_viol !== 0) begin
      n_fail++;
      $display("FAIL rw_noreq: got %0d cycles want 0", rw_viol);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 24'h0;
    cmd_wdata = 16'h0;
    rsp_ready = 1'b0;
    mem_rdata = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load_hold();
    test_error();
    test_reset_wait();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
